door_ctrl_param: RTL and testbench

DOOR_CTRL_PARAM -- requirements
Module: door_ctrl_param

---
 rtl/door_pkg.sv | 35 +++
 rtl/door_debounce.sv | 38 +++
 rtl/door_ctrl_param.sv | 180 ++++++++++++++++++
 tb/tb_door_ctrl_param.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/door_pkg.sv
// Shared types for the door controller: state codes and Moore output decode.
package door_pkg;

  // State codes are fixed; state_o exposes them directly.
  typedef enum logic [2:0] {
    StClosed  = 3'd0,
    StOpening = 3'd1,
    StHold    = 3'd2,
    StClosing = 3'd3,
    StStopped = 3'd4,
    StFault   = 3'd5
  } door_state_e;

  typedef struct packed {
    logic motor_open;
    logic motor_close;
    logic fault;
  } door_out_t;

  localparam door_out_t OutIdle  = '{motor_open: 1'b0, motor_close: 1'b0, fault: 1'b0};
  localparam door_out_t OutOpen  = '{motor_open: 1'b1, motor_close: 1'b0, fault: 1'b0};
  localparam door_out_t OutClose = '{motor_open: 1'b0, motor_close: 1'b1, fault: 1'b0};
  localparam door_out_t OutFault = '{motor_open: 1'b0, motor_close: 1'b0, fault: 1'b1};

  // At most one motor direction is ever decoded for any state.
  function automatic door_out_t decode_out(door_state_e st);
    case (st)
      StOpening: return OutOpen;
      StClosing: return OutClose;
      StFault:   return OutFault;
      default:   return OutIdle;
    endcase
  endfunction

endpackage

// File: rtl/door_debounce.sv
// One-bit debouncer: output follows the input only after DEB_CYCLES
// consecutive ena-qualified samples that differ from the current output.
module door_debounce #(
  parameter int unsigned DEB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic din,
  output logic dout
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic            dout_q;

  // Count disagreeing samples; any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else if (ena) begin
      if (din == dout_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= CntLast) begin
        dout_q <= din;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/door_ctrl_param.sv
// Automatic door controller FSM with hold timer and motion timeout.
// Define DOOR_DEBOUNCE_EN to debounce sen, stop, lim_open and lim_closed.
module door_ctrl_param
  import door_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 8,
  parameter int unsigned MOVE_TIMEOUT = 32,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DEB_CYCLES   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       sen,
  input  logic       stop,
  input  logic       lim_open,
  input  logic       lim_closed,
  input  logic       clr,
  output logic       motor_open,
  output logic       motor_close,
  output logic       fault,
  output logic [2:0] state_o
);

  // Reject configurations whose counters could not hold the programmed limits.
  if (((HOLD_CYCLES >> CNT_W) != 0) || ((MOVE_TIMEOUT >> CNT_W) != 0)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for HOLD_CYCLES/MOVE_TIMEOUT");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 1");
  end

  logic sen_f, stop_f, lim_open_f, lim_closed_f;

`ifdef DOOR_DEBOUNCE_EN
  door_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sen (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .din  (sen),
    .dout (sen_f)
  );
  door_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .din  (stop),
    .dout (stop_f)
  );
  door_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lim_open (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .din  (lim_open),
    .dout (lim_open_f)
  );
  door_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lim_closed (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .din  (lim_closed),
    .dout (lim_closed_f)
  );
`else
  assign sen_f        = sen;
  assign stop_f       = stop;
  assign lim_open_f   = lim_open;
  assign lim_closed_f = lim_closed;
`endif

  localparam logic [CNT_W-1:0] HoldLoad  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W:0]   MoveLimit = (CNT_W + 1)'(MOVE_TIMEOUT);

  door_state_e      state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] move_q, move_d;
  door_out_t        out_q;

  logic [CNT_W:0]   move_inc;
  logic             move_expired;
  logic [CNT_W-1:0] move_sat;

  // Motion time including the current cycle; saturating copy for the counter.
  assign move_inc     = {1'b0, move_q} + (CNT_W + 1)'(1);
  assign move_expired = (move_inc >= MoveLimit);
  assign move_sat     = (&move_q) ? move_q : move_inc[CNT_W-1:0];

  // Next-state and counter update; a shorted limit pair overrides everything.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    move_d  = move_q;
    if (lim_open_f && lim_closed_f) begin
      state_d = StFault;
    end else begin
      case (state_q)
        StClosed: begin
          if (sen_f && !stop_f) begin
            state_d = StOpening;
            move_d  = '0;
          end
        end
        StOpening: begin
          if (stop_f) begin
            state_d = StStopped;
          end else if (lim_open_f) begin
            state_d = StHold;
            hold_d  = HoldLoad;
          end else if (move_expired) begin
            state_d = StFault;
          end else begin
            move_d = move_sat;
          end
        end
        StHold: begin
          // The cycle that takes the counter to 0 is the last one held open.
          if (stop_f) begin
            state_d = StStopped;
          end else if (sen_f) begin
            hold_d = HoldLoad;
          end else if (hold_q <= CNT_W'(1)) begin
            state_d = StClosing;
            hold_d  = '0;
            move_d  = '0;
          end else begin
            hold_d = hold_q - CNT_W'(1);
          end
        end
        StClosing: begin
          if (stop_f) begin
            state_d = StStopped;
          end else if (sen_f) begin
            state_d = StOpening;
            move_d  = '0;
          end else if (lim_closed_f) begin
            state_d = StClosed;
          end else if (move_expired) begin
            state_d = StFault;
          end else begin
            move_d = move_sat;
          end
        end
        StStopped: begin
          if (!stop_f) begin
            state_d = StOpening;
            move_d  = '0;
          end
        end
        StFault: begin
          if (clr && !lim_open_f && !lim_closed_f) begin
            state_d = StClosing;
            move_d  = '0;
          end
        end
        default: state_d = StFault;
      endcase
    end
  end

  // State, counters and decoded outputs; reset drops the motors asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClosed;
      hold_q  <= '0;
      move_q  <= '0;
      out_q   <= OutIdle;
    end else if (ena) begin
      state_q <= state_d;
      hold_q  <= hold_d;
      move_q  <= move_d;
      out_q   <= decode_out(state_d);
    end
  end

  assign motor_open  = out_q.motor_open;
  assign motor_close = out_q.motor_close;
  assign fault       = out_q.fault;
  assign state_o     = state_q;

endmodule

// File: tb/tb_door_ctrl_param.sv
// Self-checking bench for door_ctrl_param (HOLD_CYCLES=4, MOVE_TIMEOUT=16).
module tb_door_ctrl_param;

  localparam int Hold = 4;
  localparam int Tmo  = 16;

  logic       clk, rst_n, ena, sen, stop, lim_open, lim_closed, clr;
  logic       motor_open, motor_close, fault;
  logic [2:0] state_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: state named by spec code, quiet = presence-free cycles
  // spent held open, age = cycles spent in the current motion.
  int m_state = 0;
  int m_quiet = 0;
  int m_age   = 0;

  door_ctrl_param #(
    .HOLD_CYCLES (Hold),
    .MOVE_TIMEOUT(Tmo),
    .CNT_W       (8),
    .DEB_CYCLES  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .sen        (sen),
    .stop       (stop),
    .lim_open   (lim_open),
    .lim_closed (lim_closed),
    .clr        (clr),
    .motor_open (motor_open),
    .motor_close(motor_close),
    .fault      (fault),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_step();
    if (!ena) return;
    if (lim_open && lim_closed) begin
      m_state = 5;
      return;
    end
    case (m_state)
      0: if (sen && !stop) begin m_state = 1; m_age = 0; end
      1: begin
        if (stop) m_state = 4;
        else if (lim_open) begin m_state = 2; m_quiet = 0; end
        else begin m_age++; if (m_age >= Tmo) m_state = 5; end
      end
      2: begin
        if (stop) m_state = 4;
        else if (sen) m_quiet = 0;
        else begin
          m_quiet++;
          if (m_quiet >= Hold) begin m_state = 3; m_age = 0; end
        end
      end
      3: begin
        if (stop) m_state = 4;
        else if (sen) begin m_state = 1; m_age = 0; end
        else if (lim_closed) m_state = 0;
        else begin m_age++; if (m_age >= Tmo) m_state = 5; end
      end
      4: if (!stop) begin m_state = 1; m_age = 0; end
      5: if (clr && !lim_open && !lim_closed) begin m_state = 3; m_age = 0; end
      default: m_state = 0;
    endcase
  endtask

  task automatic model_reset();
    m_state = 0;
    m_quiet = 0;
    m_age   = 0;
  endtask

  function automatic logic [5:0] model_vec();
    return {3'(m_state), m_state == 1, m_state == 3, m_state == 5};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {state_o, motor_open, motor_close, fault};
  endfunction

  task automatic drive(input logic e, input logic s, input logic st, input logic lo,
                       input logic lc, input logic c);
    ena = e; sen = s; stop = st; lim_open = lo; lim_closed = lc; clr = c;
  endtask

  // One clock: model advances on the same edge, outputs sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    n_chk++;
    if (dut_vec() !== 6'b0) begin
      n_fail++; $display("FAIL reset_async: got %b want %b", dut_vec(), 6'b0);
    end
    drive(1, 1, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) tick();
    n_chk++;
    if (dut_vec() !== 6'b0) begin
      n_fail++; $display("FAIL reset_held: got %b want %b", dut_vec(), 6'b0);
    end
    drive(1, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    tick();
    n_chk++;
    if (dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL reset_release: got %b want %b", dut_vec(), model_vec());
    end
  endtask

  task automatic test_normal_cycle();
    drive(1, 1, 0, 0, 0, 0);
    tick();
    n_chk++;
    if (state_o !== 3'd1 || motor_open !== 1'b1 || motor_close !== 1'b0) begin
      n_fail++; $display("FAIL normal_open: got st=%0d mo=%b mc=%b want st=1 mo=1 mc=0",
                         state_o, motor_open, motor_close);
    end
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL normal_opening[%0d]: got %b want %b", i, dut_vec(), model_vec());
      end
    end
    drive(1, 0, 0, 1, 0, 0);
    tick();
    n_chk++;
    if (state_o !== 3'd2 || motor_open !== 1'b0) begin
      n_fail++; $display("FAIL normal_hold: got st=%0d mo=%b want st=2 mo=0", state_o, motor_open);
    end
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= Hold; i++) begin
      tick();
      n_chk++;
      if (state_o !== ((i < Hold) ? 3'd2 : 3'd3) || dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL normal_hold_count[%0d]: got %b want %b", i, dut_vec(), model_vec());
      end
    end
    drive(1, 0, 0, 0, 1, 0);
    tick();
    n_chk++;
    if (state_o !== 3'd0 || motor_open !== 1'b0 || motor_close !== 1'b0) begin
      n_fail++; $display("FAIL normal_closed: got %b want state 0 motors 0", dut_vec());
    end
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reversal();
    drive(1, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < Hold + 2; i++) tick();
    n_chk++;
    if (state_o !== 3'd3 || motor_close !== 1'b1) begin
      n_fail++; $display("FAIL rev_closing: got st=%0d mc=%b want st=3 mc=1", state_o, motor_close);
    end
    drive(1, 1, 0, 0, 1, 0);
    tick();
    n_chk++;
    if (state_o !== 3'd1 || motor_open !== 1'b1 || motor_close !== 1'b0) begin
      n_fail++; $display("FAIL rev_reopen: got st=%0d mo=%b mc=%b want st=1 mo=1 mc=0",
                         state_o, motor_open, motor_close);
    end
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    // Continues from the freshly re-entered OPENING state.
    for (int i = 1; i <= Tmo; i++) begin
      tick();
      n_chk++;
      if (state_o !== ((i < Tmo) ? 3'd1 : 3'd5) || dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL timeout[%0d]: got %b want %b", i, dut_vec(), model_vec());
      end
    end
    n_chk++;
    if (fault !== 1'b1 || motor_open !== 1'b0) begin
      n_fail++; $display("FAIL timeout_fault: got fault=%b mo=%b want 1 0", fault, motor_open);
    end
    drive(1, 0, 0, 0, 0, 1);
    tick();
    n_chk++;
    if (state_o !== 3'd3 || fault !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clr: got st=%0d fault=%b want st=3 fault=0", state_o, fault);
    end
    drive(1, 0, 0, 0, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_both_limits();
    drive(1, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 1, 1, 0);
    tick();
    n_chk++;
    if (state_o !== 3'd5 || fault !== 1'b1) begin
      n_fail++; $display("FAIL limits_fault: got st=%0d fault=%b want st=5 fault=1", state_o, fault);
    end
    drive(1, 0, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (state_o !== 3'd5) begin
        n_fail++; $display("FAIL limits_clr_ignored[%0d]: got st=%0d want 5", i, state_o);
      end
    end
    drive(1, 0, 0, 0, 0, 1);
    tick();
    n_chk++;
    if (state_o !== 3'd3 || dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL limits_clr: got %b want %b", dut_vec(), model_vec());
    end
    drive(1, 0, 0, 0, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stop_ena();
    int waited;
    drive(1, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0); tick(); tick();
    drive(1, 0, 1, 0, 0, 0);
    tick();
    n_chk++;
    if (state_o !== 3'd4 || motor_open !== 1'b0 || motor_close !== 1'b0) begin
      n_fail++; $display("FAIL stop_stopped: got %b want state 4 motors 0", dut_vec());
    end
    tick();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    n_chk++;
    if (state_o !== 3'd1 || motor_open !== 1'b1) begin
      n_fail++; $display("FAIL stop_resume: got st=%0d mo=%b want st=1 mo=1", state_o, motor_open);
    end
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      n_chk++;
      if (state_o !== 3'd1 || dut_vec() !== model_vec()) begin
        n_fail++; $display("FAIL ena_freeze[%0d]: got %b want %b", i, dut_vec(), model_vec());
      end
    end
    // Three motion cycles were already spent before the freeze.
    drive(1, 0, 0, 0, 0, 0);
    waited = 0;
    while (state_o === 3'd1 && waited < 40) begin
      tick();
      waited++;
    end
    n_chk++;
    if (waited != Tmo - 3 || state_o !== 3'd5) begin
      n_fail++; $display("FAIL ena_counter_held: got %0d cycles st=%0d want %0d cycles st=5",
                         waited, state_o, Tmo - 3);
    end
    drive(1, 0, 0, 0, 0, 1); tick();
    drive(1, 0, 0, 0, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    drive(1, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < Hold + 1; i++) tick();
    n_chk++;
    if (motor_close !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre: got mc=%b want 1", motor_close);
    end
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (motor_close !== 1'b0 || state_o !== 3'd0) begin
      n_fail++; $display("FAIL arst_immediate: got mc=%b st=%0d want mc=0 st=0", motor_close, state_o);
    end
    #2 rst_n = 1'b1;
    tick();
    n_chk++;
    if (state_o !== 3'd0 || dut_vec() !== model_vec()) begin
      n_fail++; $display("FAIL arst_release: got %b want %b", dut_vec(), model_vec());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(99) < 90, $urandom_range(99) < 25, $urandom_range(99) < 8,
            $urandom_range(99) < 20, $urandom_range(99) < 20, $urandom_range(99) < 25);
      tick();
      n_chk++;
      if (dut_vec() !== model_vec() || (motor_open && motor_close)) begin
        n_fail++; $display("FAIL random[%0d]: got %b want %b", i, dut_vec(), model_vec());
      end
    end
    drive(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_reversal();
    test_timeout();
    test_both_limits();
    test_stop_ena();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
